// File: rtl/axis_burst_reader_pkg.sv
// Shared types and helpers for the burst reader.
// State encoding, burst-size arithmetic and clogb2.
package axis_burst_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n)
                r = i + 1;
        return r;
    endfunction

    // Bytes covered by one burst (BB).
    function automatic int burst_bytes(input int len, input int dw);
        return len * (dw / 8);
    endfunction

endpackage

// File: rtl/axis_burst_reader_if.sv
// AXI4-Stream bundle carried by the burst reader.
interface axis_burst_reader_if #(
    parameter int DW = 32
);
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;

    modport master (
        output M_AXIS_TDATA,
        output M_AXIS_TVALID,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TDATA,
        input  M_AXIS_TVALID,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/axis_burst_reader_skid.sv
// Two-entry registered skid buffer; output regs plus one overflow slot.
module axis_skid_buffer #(
    parameter int DW = 32
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESET,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 empty,
    axis_burst_reader_if.master  m_axis
);
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          skid_last;
    logic          pop;
    logic          accept;

    assign pop      = out_valid && m_axis.M_AXIS_TREADY;
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign empty    = !out_valid && !skid_valid;

    assign m_axis.M_AXIS_TVALID = out_valid;
    assign m_axis.M_AXIS_TDATA  = out_data;
    assign m_axis.M_AXIS_TLAST  = out_last;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (!out_valid || pop) begin
            // Output slot frees up: refill from skid first to keep order.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_last  <= in_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_last  <= in_last;
        end
    end

endmodule

// File: rtl/axis_burst_reader.sv
// Memory-to-stream read sequencer: issues N bursts, forwards beats
// to AXI4-Stream through a skid buffer, TLAST on the final beat.
module axis_burst_reader
    import axis_burst_reader_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 256,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_address,
    input  logic [C_CNT_WIDTH-1:0]        cmd_bursts,
    input  logic                          cmd_start,
    output logic                          cmd_busy,
    output logic                          cmd_done,
    output logic                          cmd_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] read_address,
    output logic                          read_start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] read_data,
    input  logic                          read_data_valid,
    input  logic                          read_data_last,
    output logic                          read_ready,
    input  logic                          read_end,
    input  logic                          output_idle,
    input  logic                          output_error,
    axis_burst_reader_if.master           m_axis
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int CW = C_CNT_WIDTH;
    localparam int BB = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
    localparam int BW = clogb2(C_M_AXI_BURST_LEN) + 1;

    localparam logic [AW-1:0] BB_A     = AW'(BB);
    localparam logic [AW-1:0] BB_MASK  = BB_A - AW'(1);
    localparam logic [BW-1:0] LAST_IDX = BW'(C_M_AXI_BURST_LEN - 1);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] rem_q;
    logic [BW-1:0] beat_q;
    logic          err_q;

    logic sk_ready;
    logic sk_empty;
    logic beat_acc;
    logic beat_is_last;
    logic rem_is_one;
    logic misaligned;
    logic start_acc;
    logic in_last;

    assign start_acc    = (state_q == ST_IDLE) && cmd_start;
    assign misaligned   = (cmd_address & BB_MASK) != '0;
    assign beat_is_last = beat_q == LAST_IDX;
    assign rem_is_one   = rem_q == CW'(1);
    assign beat_acc     = read_data_valid && read_ready;
    assign in_last      = rem_is_one && beat_is_last;
    assign cmd_error    = err_q;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (cmd_start)
                    state_d = (cmd_bursts == '0 || misaligned) ?
                              ST_DONE : ST_ISSUE;
            ST_ISSUE:
                if (output_idle)
                    state_d = ST_STREAM;
            ST_STREAM:
                if (read_end)
                    state_d = rem_is_one ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN:
                if (sk_empty)
                    state_d = ST_DONE;
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_busy     = state_q != ST_IDLE;
        cmd_done     = state_q == ST_DONE;
        read_start   = (state_q == ST_ISSUE) && output_idle;
        read_ready   = (state_q == ST_STREAM) && sk_ready;
        read_address = addr_q;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_q <= '0;
            rem_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                addr_q <= cmd_address;
                rem_q  <= cmd_bursts;
                err_q  <= misaligned;
            end else begin
                if (state_q != ST_IDLE && output_error)
                    err_q <= 1'b1;
                // Master's last flag must agree with our own beat count.
                if (beat_acc && (read_data_last != beat_is_last))
                    err_q <= 1'b1;
            end

            if (read_start)
                beat_q <= '0;
            else if (beat_acc)
                beat_q <= beat_q + BW'(1);

            if (state_q == ST_STREAM && read_end && !rem_is_one) begin
                addr_q <= addr_q + BB_A;
                rem_q  <= rem_q - CW'(1);
            end
        end
    end

    axis_skid_buffer #(
        .DW (C_M_AXI_DATA_WIDTH)
    ) u_skid (
        .M_AXI_ACLK   (M_AXI_ACLK),
        .M_AXI_ARESET (M_AXI_ARESET),
        .in_valid     (beat_acc),
        .in_data      (read_data),
        .in_last      (in_last),
        .in_ready     (sk_ready),
        .empty        (sk_empty),
        .m_axis       (m_axis)
    );

endmodule

// File: tb/tb_axis_burst_reader.sv
// Bench for axis_burst_reader: read-master model, stream scoreboard,
// table of commands plus reset and zero-burst sequences.
module tb_axis_burst_reader;
    import axis_burst_reader_pkg::*;

    localparam int BL = 4;
    localparam int BB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd_address = '0;
    logic [15:0] cmd_bursts = '0;
    logic        cmd_start = 1'b0;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    logic [31:0] read_address;
    logic        read_start;
    logic [31:0] read_data = '0;
    logic        read_data_valid = 1'b0;
    logic        read_data_last = 1'b0;
    logic        read_ready;
    logic        read_end = 1'b0;
    logic        output_idle = 1'b1;
    logic        output_error = 1'b0;

    axis_burst_reader_if #(.DW(32)) axis ();

    axis_burst_reader #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_BURST_LEN  (BL),
        .C_CNT_WIDTH        (16)
    ) dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESET    (rst),
        .cmd_address     (cmd_address),
        .cmd_bursts      (cmd_bursts),
        .cmd_start       (cmd_start),
        .cmd_busy        (cmd_busy),
        .cmd_done        (cmd_done),
        .cmd_error       (cmd_error),
        .read_address    (read_address),
        .read_start      (read_start),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .read_data_last  (read_data_last),
        .read_ready      (read_ready),
        .read_end        (read_end),
        .output_idle     (output_idle),
        .output_error    (output_error),
        .m_axis          (axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] bursts;
        bit          tmode;
        int          badpos;
        bit          poke;
        bit          oerr;
        int          nstarts;
        int          nbeats;
        bit          err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Master model / monitor state
    bit          tmode = 1'b0;
    int          badpos = BL - 1;
    logic [31:0] starts_q[$];
    logic [32:0] beats_q[$];
    int          done_cnt = 0;
    int          bad_cnt = 0;
    bit          busy = 1'b0;
    int          beat_i = 0;
    logic [31:0] baddr = '0;
    bit          took_start = 1'b0;
    bit          took_beat = 1'b0;
    logic [31:0] lat_addr = '0;
    int          occ = 0;
    int          cyc = 0;
    bit          pop = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            beat_i = 0;
            took_start = 1'b0;
            took_beat = 1'b0;
            occ = 0;
            prev_stall = 1'b0;
            read_data = '0;
            read_data_valid = 1'b0;
            read_data_last = 1'b0;
            read_end = 1'b0;
            output_idle = 1'b1;
            axis.M_AXIS_TREADY = 1'b0;
        end else begin
            if (took_start) begin
                busy = 1'b1;
                beat_i = 0;
                baddr = lat_addr;
            end
            if (took_beat)
                beat_i++;
            read_end = busy && (beat_i == BL);
            if (read_end)
                busy = 1'b0;
            output_idle = !busy;
            read_data_valid = busy && (beat_i < BL);
            read_data = baddr + 32'(beat_i * 4);
            read_data_last = read_data_valid && (beat_i == badpos);
            axis.M_AXIS_TREADY = tmode ? cyc[0] : 1'b1;
            cyc++;
            #1;
            took_start = read_start;
            lat_addr = read_address;
            if (read_start)
                starts_q.push_back(read_address);
            took_beat = read_data_valid && read_ready;
            pop = axis.M_AXIS_TVALID && axis.M_AXIS_TREADY;
            if (prev_stall && !(axis.M_AXIS_TVALID &&
                axis.M_AXIS_TDATA == pd && axis.M_AXIS_TLAST == pl))
                bad_cnt++;
            if (occ >= 2 && read_ready)
                bad_cnt++;
            if (pop)
                beats_q.push_back({axis.M_AXIS_TLAST, axis.M_AXIS_TDATA});
            prev_stall = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
            pd = axis.M_AXIS_TDATA;
            pl = axis.M_AXIS_TLAST;
            if (cmd_done)
                done_cnt++;
            occ = occ + int'(took_beat) - int'(pop);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int s0, b0, d0, k0;
        logic [31:0] ea;
        s0 = starts_q.size();
        b0 = beats_q.size();
        d0 = done_cnt;
        k0 = bad_cnt;
        @(negedge clk);
        tmode = v.tmode;
        badpos = v.badpos;
        @(negedge clk);
        cmd_address = v.addr;
        cmd_bursts = v.bursts;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        if (v.poke) begin
            repeat (3) @(negedge clk);
            cmd_address = 32'h3;
            cmd_bursts = 16'd5;
            cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
        end
        if (v.oerr) begin
            repeat (2) @(negedge clk);
            output_error = 1'b1;
            @(negedge clk);
            output_error = 1'b0;
        end
        for (int t = 0; t < 3000 && done_cnt == d0; t++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        chk("starts", 64'(starts_q.size() - s0), 64'(v.nstarts));
        for (int i = 0; i < v.nstarts && s0 + i < starts_q.size(); i++) begin
            ea = v.addr + 32'(i * BB);
            chk("start_addr", 64'(starts_q[s0+i]), 64'(ea));
        end
        chk("beats", 64'(beats_q.size() - b0), 64'(v.nbeats));
        for (int k = 0; k < v.nbeats && b0 + k < beats_q.size(); k++) begin
            ea = v.addr + 32'(k * 4);
            chk("beat", 64'(beats_q[b0+k]),
                64'({k == v.nbeats - 1, ea}));
        end
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("error", 64'(cmd_error), 64'(v.err));
        chk("busy_after", 64'(cmd_busy), 64'd0);
        chk("stream_rules", 64'(bad_cnt - k0), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t v6;
    int   s0, d0, lat;

    initial begin
        vecs[0] = '{32'h1000, 16'd3, 1'b0, 3, 1'b0, 1'b0, 3, 12, 1'b0};
        vecs[1] = '{32'h1000, 16'd3, 1'b1, 3, 1'b0, 1'b0, 3, 12, 1'b0};
        vecs[2] = '{32'h1000, 16'd0, 1'b0, 3, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{32'h1004, 16'd1, 1'b0, 3, 1'b0, 1'b0, 0, 0, 1'b1};
        vecs[4] = '{32'h1000, 16'd1, 1'b0, 2, 1'b0, 1'b0, 1, 4, 1'b1};
        vecs[5] = '{32'hFFFF_FFF0, 16'd2, 1'b0, 3, 1'b0, 1'b0, 2, 8, 1'b0};
        vecs[6] = '{32'h3000, 16'd2, 1'b1, 3, 1'b1, 1'b0, 2, 8, 1'b0};
        vecs[7] = '{32'h4000, 16'd1, 1'b0, 3, 1'b0, 1'b1, 1, 4, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({cmd_busy, cmd_done, cmd_error, read_start,
            read_ready, axis.M_AXIS_TVALID, axis.M_AXIS_TLAST}), 64'd0);
        chk("reset_addr", 64'(read_address), 64'd0);
        chk("reset_tdata", 64'(axis.M_AXIS_TDATA), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_cmd(vecs[i]);

        // Zero-burst command: done follows start directly, no bus traffic.
        s0 = starts_q.size();
        d0 = done_cnt;
        lat = -1;
        @(negedge clk);
        cmd_address = 32'h1000;
        cmd_bursts = 16'd0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            if (cmd_done && lat < 0)
                lat = t;
            @(negedge clk);
        end
        chk("zero_latency_ok", 64'(lat >= 1 && lat <= 2), 64'd1);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);
        chk("zero_no_start", 64'(starts_q.size() - s0), 64'd0);

        // Reset in the middle of the second burst.
        tmode = 1'b0;
        badpos = BL - 1;
        s0 = starts_q.size();
        @(negedge clk);
        cmd_address = 32'h1000;
        cmd_bursts = 16'd3;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int t = 0; t < 500 && starts_q.size() < s0 + 2; t++)
            @(negedge clk);
        chk("reached_burst2", 64'(starts_q.size() - s0), 64'd2);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_ctl", 64'({cmd_busy, cmd_done, cmd_error, read_start,
            read_ready, axis.M_AXIS_TVALID, axis.M_AXIS_TLAST}), 64'd0);
        chk("midreset_addr", 64'(read_address), 64'd0);
        chk("midreset_tdata", 64'(axis.M_AXIS_TDATA), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
        v6 = '{32'h2000, 16'd1, 1'b0, 3, 1'b0, 1'b0, 1, 4, 1'b0};
        run_cmd(v6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
